// File: rtl/fpaddsub_pkg.sv
// Shared definitions for the FP add/sub datapath: default field widths and
// the pipeline stage-count helper.
`define MANTISSA 10
`define EXPONENT 5

package fpaddsub_pkg;

   localparam int FP_MAN_W = `MANTISSA;
   localparam int FP_EXP_W = `EXPONENT;

   // Number of pipeline stages needed to hold all shift levels.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/fpaddsub_shift_level.sv
// One level of the logarithmic alignment shifter: optional right shift by a
// fixed power of two, folding the dropped bits into the sticky flag.
module fpaddsub_shift_level #(
    parameter int AMT   = 1,
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] w_in,
    input  logic             s_in,
    input  logic             en,
    output logic [WIDTH-1:0] w_out,
    output logic             s_out
);

    // A level wider than the word flushes everything into sticky.
    generate
        if (AMT >= WIDTH) begin : g_flush
            assign w_out = en ? '0 : w_in;
            assign s_out = s_in | (en & (|w_in));
        end else begin : g_shift
            assign w_out = en ? (w_in >> AMT) : w_in;
            assign s_out = s_in | (en & (|w_in[AMT-1:0]));
        end
    endgenerate

endmodule

// File: rtl/fpaddsub_align_shift_pipe.sv
// Pipelined alignment right-shifter producing {mantissa, guard, round} plus
// sticky, with a valid/ready handshake and a pass-through tag.
module fpaddsub_align_shift_pipe
    import fpaddsub_pkg::*;
#(
    parameter int MAN_W       = FP_MAN_W,
    parameter int SHIFT_W     = 5,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W:0]     in_mant,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W+2:0]   out_mant,
    output logic               out_sticky,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int WW   = MAN_W + 3;
    localparam int NSTG = ceil_div(SHIFT_W, LVL_PER_STG);

    logic [NSTG-1:0]    v;
    logic [WW-1:0]      w_q   [NSTG];
    logic [NSTG-1:0]    s_q;
    logic [SHIFT_W-1:0] sh_q  [NSTG];
    logic [TAG_W-1:0]   tag_q [NSTG];

    logic [WW-1:0]      w_src   [NSTG];
    logic [NSTG-1:0]    s_src;
    logic [NSTG-1:0]    v_src;
    logic [SHIFT_W-1:0] sh_src  [NSTG];
    logic [TAG_W-1:0]   tag_src [NSTG];
    logic [WW-1:0]      w_nx    [NSTG];
    logic [NSTG-1:0]    s_nx;

    logic [WW-1:0]      lw_in  [SHIFT_W];
    logic [WW-1:0]      lw_out [SHIFT_W];
    logic [SHIFT_W-1:0] ls_in;
    logic [SHIFT_W-1:0] ls_out;
    logic [SHIFT_W-1:0] l_en;

    logic [NSTG-1:0]    ld;
    logic [NSTG-1:0]    adv;

    // Stage inputs come from the ports for stage 0, otherwise from the
    // previous stage's registers; each stage's result is its last level.
    generate
        for (genvar s = 0; s < NSTG; s++) begin : g_stage
            localparam int LAST = (((s + 1) * LVL_PER_STG < SHIFT_W) ?
                                   (s + 1) * LVL_PER_STG : SHIFT_W) - 1;
            if (s == 0) begin : g_first
                assign w_src[s]   = {in_mant, 2'b00};
                assign s_src[s]   = 1'b0;
                assign v_src[s]   = in_valid;
                assign sh_src[s]  = in_shift;
                assign tag_src[s] = in_tag;
            end else begin : g_next
                assign w_src[s]   = w_q[s-1];
                assign s_src[s]   = s_q[s-1];
                assign v_src[s]   = v[s-1];
                assign sh_src[s]  = sh_q[s-1];
                assign tag_src[s] = tag_q[s-1];
            end
            assign w_nx[s] = lw_out[LAST];
            assign s_nx[s] = ls_out[LAST];
        end

        for (genvar k = 0; k < SHIFT_W; k++) begin : g_level
            localparam int ST = k / LVL_PER_STG;
            if ((k % LVL_PER_STG) == 0) begin : g_head
                assign lw_in[k] = w_src[ST];
                assign ls_in[k] = s_src[ST];
            end else begin : g_chain
                assign lw_in[k] = lw_out[k-1];
                assign ls_in[k] = ls_out[k-1];
            end
            assign l_en[k] = sh_src[ST][k];

            fpaddsub_shift_level #(
                .AMT   (1 << k),
                .WIDTH (WW)
            ) u_level (
                .w_in  (lw_in[k]),
                .s_in  (ls_in[k]),
                .en    (l_en[k]),
                .w_out (lw_out[k]),
                .s_out (ls_out[k])
            );
        end
    endgenerate

    // Backpressure ripples from the output towards the input so that a full
    // pipe can drain and refill in the same cycle.
    always_comb begin
        adv = '0;
        ld  = '0;
        adv[NSTG-1] = out_ready;
        ld[NSTG-1]  = !v[NSTG-1] || out_ready;
        for (int s = NSTG - 2; s >= 0; s--) begin
            adv[s] = ld[s+1];
            ld[s]  = !v[s] || adv[s];
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            s_q <= '0;
            for (int s = 0; s < NSTG; s++) begin
                w_q[s]   <= '0;
                sh_q[s]  <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                if (ld[s]) begin
                    v[s] <= v_src[s];
                    if (v_src[s]) begin
                        w_q[s]   <= w_nx[s];
                        s_q[s]   <= s_nx[s];
                        sh_q[s]  <= sh_src[s];
                        tag_q[s] <= tag_src[s];
                    end
                end
            end
        end
    end

    assign out_valid  = v[NSTG-1];
    assign out_mant   = w_q[NSTG-1];
    assign out_sticky = s_q[NSTG-1];
    assign out_tag    = tag_q[NSTG-1];

endmodule

// File: tb/tb_fpaddsub_align_shift_pipe.sv
// Scoreboard bench for the alignment shifter: the driver queues expected
// beats on acceptance, an independent monitor checks each delivered beat.
module tb_fpaddsub_align_shift_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_mant;
    logic [4:0]  in_shift;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_mant;
    logic        out_sticky;
    logic [7:0]  out_tag;

    typedef struct {
        logic [12:0] mant;
        logic        sticky;
        logic [7:0]  tag;
        bit          chk_lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   rand_done;

    fpaddsub_align_shift_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_shift   (in_shift),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_sticky (out_sticky),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: shift a wide zero-extended word in one go and split it.
    task automatic refModel(input logic [10:0] mant, input logic [4:0] sh,
                            output logic [12:0] em, output logic es);
        logic [43:0] x;
        x  = {mant, 2'b00, 31'b0} >> sh;
        em = x[43:31];
        es = |x[30:0];
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input logic [10:0] mant, input logic [4:0] sh,
                                 input logic [7:0] tag, input logic [12:0] em,
                                 input logic es, input bit push, input bit lat);
        bit accepted = 0;
        int waited = 0;
        exp_t e;
        in_valid = 1'b1;
        in_mant  = mant;
        in_shift = sh;
        in_tag   = tag;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready && !rst) accepted = 1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL accept_timeout: tag %0h never accepted", tag);
        end else if (push) begin
            e.mant = em; e.sticky = es; e.tag = tag; e.chk_lat = lat; e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every delivered beat must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("[TB] FAIL unexpected_beat: got tag %0h, expected no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_mant", 32'(out_mant), 32'(e.mant));
                    checkOutput("out_sticky", 32'(out_sticky), 32'(e.sticky));
                    checkOutput("out_tag", 32'(out_tag), 32'(e.tag));
                    if (e.chk_lat) checkOutput("latency", 32'(cyc - e.acc), 32'd3);
                end
            end
        end
    end

    // Stall monitor: a presented but unaccepted beat must not change.
    initial begin
        bit          held = 0;
        logic [12:0] hm;
        logic        hs;
        logic [7:0]  ht;
        forever begin
            @(negedge clk);
            if (held) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_bits", {10'b0, out_mant, out_sticky, out_tag},
                            {10'b0, hm, hs, ht});
            end
            held = out_valid && !out_ready && !rst;
            hm = out_mant; hs = out_sticky; ht = out_tag;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [12:0] em;
        logic        es;
        logic [10:0] rm;
        logic [4:0]  rs;

        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_shift = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_mant", 32'(out_mant), 32'd0);
        checkOutput("rst_out_sticky", 32'(out_sticky), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        applyStimulus(11'h400, 5'd0,  8'hA0, 13'h1000, 1'b0, 1, 1);
        repeat (4) begin @(posedge clk); #1; end
        applyStimulus(11'h407, 5'd3,  8'hA1, 13'h0203, 1'b1, 1, 0);
        applyStimulus(11'h400, 5'd12, 8'hA2, 13'h0001, 1'b0, 1, 0);
        applyStimulus(11'h400, 5'd13, 8'hA3, 13'h0000, 1'b1, 1, 0);
        applyStimulus(11'h400, 5'd31, 8'hA4, 13'h0000, 1'b1, 1, 0);
        applyStimulus(11'h000, 5'd31, 8'hA5, 13'h0000, 1'b0, 1, 0);
        applyStimulus(11'h7FF, 5'd1,  8'hA6, 13'h0FFE, 1'b0, 1, 0);
        applyStimulus(11'h7FF, 5'd2,  8'hA7, 13'h07FF, 1'b0, 1, 0);
        applyStimulus(11'h7FF, 5'd3,  8'hA8, 13'h03FF, 1'b1, 1, 0);
        applyStimulus(11'h401, 5'd16, 8'hA9, 13'h0000, 1'b1, 1, 0);

        $display("[TB] stream with stall");
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    rm = 11'(11'h400 + i * 53);
                    rs = 5'(i % 14);
                    refModel(rm, rs, em, es);
                    applyStimulus(rm, rs, 8'(i), em, es, 1, 0);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(negedge clk);
                checkOutput("full_in_ready", 32'(in_ready), 32'd0);
                checkOutput("full_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                checkOutput("drain_fill_in_ready", 32'(in_ready), 32'd1);
            end
        join
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        $display("[TB] random backpressure");
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    rm = 11'($urandom_range(0, 2047));
                    rs = 5'($urandom_range(0, 31));
                    refModel(rm, rs, em, es);
                    applyStimulus(rm, rs, 8'($urandom_range(0, 255)), em, es, 1, 0);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("random_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        $display("[TB] reset flush");
        out_ready = 1'b0;
        applyStimulus(11'h123, 5'd1, 8'hF0, 13'h0, 1'b0, 0, 0);
        applyStimulus(11'h234, 5'd2, 8'hF1, 13'h0, 1'b0, 0, 0);
        applyStimulus(11'h345, 5'd3, 8'hF2, 13'h0, 1'b0, 0, 0);
        rst = 1'b1;
        in_valid = 1'b1; in_mant = 11'h7AA; in_shift = 5'd4; in_tag = 8'hEE;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        applyStimulus(11'h407, 5'd3, 8'h55, 13'h0203, 1'b1, 1, 1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("final_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpaddsub_align_shift_pipe.md
# fpaddsub_align_shift_pipe

Parametrised, pipelined alignment right-shifter for the FP add/sub datapath. It replaces the fixed two-stage 16|12|8|4 + 3|2|1 split with a single logarithmic shifter that zero-fills from the left and produces guard, round and sticky bits for the rounding stage. A configurable number of shift levels sits between pipeline registers, and a valid/ready handshake with backpressure passes a sideband tag through. It sits between exponent-difference and mantissa add/sub.

## Interface
- MAN_W, 10 — stored mantissa width; input carries hidden bit, so MAN_W+1 bits
- SHIFT_W, 5 — shift-amount width; levels = SHIFT_W, max shift 2^SHIFT_W−1
- LVL_PER_STG, 2 — shift levels per pipeline stage (≥1)
- TAG_W, 8 — sideband tag width, passed through unchanged
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_mant  in  MAN_W+1  smaller mantissa, hidden bit at MSB
- in_shift  in  SHIFT_W  exponent difference (right-shift amount)
- in_tag  in  TAG_W  sideband
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mant  out  MAN_W+3  shifted {mantissa, guard, round}
- out_sticky  out  1  OR of all bits shifted below round
- out_tag  out  TAG_W  tag of this beat

## Operation
- Working word W = {in_mant, 2'b00} (MAN_W+3 bits), sticky S = 0.
- Level k (k = 0..SHIFT_W−1): if in_shift[k], then W ← W >> 2^k (zero fill at MSB) and S ← S | (OR of the 2^k bits dropped). Levels are applied in ascending k.
- Shifts ≥ MAN_W+3 give W = 0 and S = |in_mant. This needs no special case, but must hold for every value up to 2^SHIFT_W−1.
- out_mant = final W; out_sticky = final S. out_mant[1] is guard, out_mant[0] is round.
- Pipeline: NSTG = ceil(SHIFT_W/LVL_PER_STG) register stages. Stage s executes levels s·LVL_PER_STG … min((s+1)·LVL_PER_STG, SHIFT_W)−1 combinationally, then registers W, S, the remaining shift bits, the tag and a valid bit.
- Stall rule per stage: the stage loads when it is empty or when its contents advance this cycle. Bubbles collapse.
- in_ready = !v[0] || advance[0]. The last stage advances when out_ready. Stage s advances when stage s+1 loads.
- out_valid, out_mant, out_sticky and out_tag are driven from the last stage registers.
- A beat is never dropped or duplicated; order is preserved.

## Timing
- Latency is exactly NSTG cycles from accepted input (in_valid && in_ready) to out_valid with no backpressure. Defaults give NSTG = 3.
- Throughput is 1 beat/cycle while out_ready stays high.
- While out_valid && !out_ready, out_mant, out_sticky and out_tag must stay stable.
- in_ready may depend combinationally on out_ready; no other combinational input-to-output path exists.
- Reset: all stage valid bits are 0, all data registers are 0. After reset, out_valid=0, out_mant=0, out_sticky=0, out_tag=0, and in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation flushes all in-flight beats with no output. Inputs presented while rst=1 are ignored.
- Full pipe with out_ready=0: in_ready=0. Raising out_ready makes in_ready=1 in the same cycle, so simultaneous drain and fill is allowed.

## Structure
- Shared package fpaddsub_pkg holds:
  - MAN_W/EXP_W defaults matching the `MANTISSA/`EXPONENT macros
  - the stage-count function ceil_div(SHIFT_W, LVL_PER_STG)
- Sub-module fpaddsub_shift_level (parameter AMT = 2^k, width MAN_W+3):
  - inputs: W, S, enable bit
  - outputs: shifted W, updated S; purely combinational
  - instantiated SHIFT_W times via generate
- The top level contains only the stage registers and the handshake logic.

## Test plan
All scenarios use defaults (MAN_W=10, SHIFT_W=5, LVL_PER_STG=2, NSTG=3).
- in_mant=11'h400, shift=0 → out_mant=13'h1000, sticky=0, out_valid exactly 3 cycles after accept.
- in_mant=11'h407, shift=3 → out_mant=13'h0203, sticky=1.
- in_mant=11'h400, shift=12 → out_mant=13'h0001, sticky=0. Same input with shift=13 or 31 → out_mant=0, sticky=1. in_mant=0, shift=31 → 0, sticky=0.
- Back-to-back stream of 20 beats with tags 0..19, out_ready held low for 5 cycles mid-stream:
  - in_ready drops when the pipe is full
  - output holds stable while stalled
  - all 20 tags emerge in order, none lost or duplicated
- Random out_ready (50%) with 1000 random beats, checked against a reference model: mantissa, sticky and tag exact, order preserved.
- rst asserted for 1 cycle with 3 beats in flight → no output for those beats, out_valid=0 next cycle, in_ready=1 the cycle after reset releases, and the next beat emerges 3 cycles after accept.
